// File: rtl/fifo_wr_framer.sv
// Write-side framer: splits one- or two-byte result words into FIFO byte writes under Wfull backpressure.
// Optional macro FIFO_WR_FRAMER_HI_FIRST_EN sends the high byte of wide words first.
module fifo_wr_framer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    Wclk,
    input  logic                    Wrst,
    input  logic [2*DATA_WIDTH-1:0] In_data,
    input  logic                    In_wide,
    input  logic                    In_valid,
    output logic                    In_ready,
    input  logic                    Wfull,
    output logic [DATA_WIDTH-1:0]   Wdata,
    output logic                    Winc,
    output logic                    Busy,
    output logic [CNT_WIDTH-1:0]    Byte_cnt
);

    localparam int unsigned WORD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t                  state;
    state_t                  nxt_state;
    logic [WORD_WIDTH-1:0]   hold_data;
    logic                    hold_wide;
    logic                    handshake;
    logic                    commit;
    logic                    load;
    logic                    nxt_winc;
    logic [DATA_WIDTH-1:0]   nxt_wdata;
    logic [DATA_WIDTH-1:0]   first_byte_in;
    logic [DATA_WIDTH-1:0]   first_byte_hold;
    logic [DATA_WIDTH-1:0]   second_byte_hold;

    assign In_ready  = (state == IDLE) & ~Wrst;
    assign Busy      = (state != IDLE);
    assign handshake = In_valid & In_ready;
    assign commit    = Winc & ~Wfull;

    // Byte ordering; narrow words always send the low byte.
`ifdef FIFO_WR_FRAMER_HI_FIRST_EN
    assign first_byte_in    = In_wide ? In_data[WORD_WIDTH-1:DATA_WIDTH] : In_data[DATA_WIDTH-1:0];
    assign first_byte_hold  = hold_wide ? hold_data[WORD_WIDTH-1:DATA_WIDTH] : hold_data[DATA_WIDTH-1:0];
    assign second_byte_hold = hold_data[DATA_WIDTH-1:0];
`else
    assign first_byte_in    = In_data[DATA_WIDTH-1:0];
    assign first_byte_hold  = hold_data[DATA_WIDTH-1:0];
    assign second_byte_hold = hold_data[WORD_WIDTH-1:DATA_WIDTH];
`endif

    // Next state and next registered write-port values.
    always_comb begin
        nxt_state = state;
        nxt_wdata = Wdata;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    load      = 1'b1;
                    nxt_state = FIRST;
                    nxt_wdata = first_byte_in;
                end
            end
            FIRST: begin
                if (!Wfull) begin
                    if (hold_wide) begin
                        nxt_state = SECOND;
                        nxt_wdata = second_byte_hold;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else begin
                    nxt_wdata = first_byte_hold;
                end
            end
            SECOND: begin
                if (!Wfull) begin
                    nxt_state = IDLE;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
        nxt_winc = (nxt_state != IDLE);
    end

    // State, capture register and registered outputs.
    always_ff @(posedge Wclk) begin
        if (Wrst) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_wide <= 1'b0;
            Winc      <= 1'b0;
            Wdata     <= '0;
            Byte_cnt  <= '0;
        end else begin
            state <= nxt_state;
            Winc  <= nxt_winc;
            Wdata <= nxt_wdata;
            if (load) begin
                hold_data <= In_data;
                hold_wide <= In_wide;
            end
            if (commit) begin
                Byte_cnt <= Byte_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
